// File: rtl/ninjakun_shram_arb.sv
// Two-CPU shared-RAM arbiter: stalls each CPU while it waits, then runs IDLE->ACC->CAP->FIN per access.
// Optional macro SHRAM_ARB_FAIR_EN selects round-robin arbitration; otherwise CPU0 has fixed priority.
module ninjakun_shram_arb #(
  parameter int AW = 11
) (
  input  logic          MCLK,
  input  logic          RESET_N,
  input  logic          CS_SH0,
  input  logic          CP0RD,
  input  logic          CP0WR,
  input  logic [AW-1:0] CP0AD,
  input  logic [7:0]    CP0DO,
  output logic [7:0]    CP0DI,
  output logic          CP0WAIT_N,
  input  logic          CS_SH1,
  input  logic          CP1RD,
  input  logic          CP1WR,
  input  logic [AW-1:0] CP1AD,
  input  logic [7:0]    CP1DO,
  output logic [7:0]    CP1DI,
  output logic          CP1WAIT_N,
  output logic [AW-1:0] SHAD,
  output logic [7:0]    SHDO,
  output logic          SHWE,
  input  logic [7:0]    SHDI
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, CAP = 2'd2, FIN = 2'd3} state_t;

  state_t          state_reg, state_next;
  logic [1:0]      req, pend, wr_in;
  logic [AW-1:0]   ad_in [2];
  logic [7:0]      do_in [2];
  logic [7:0]      di_vec [2];
  logic            gnt_reg, wr_reg, shwe_reg, sel, start;
  logic [AW-1:0]   shad_reg;
  logic [7:0]      shdo_reg;

  assign req[0]   = CS_SH0 & (CP0RD | CP0WR);
  assign req[1]   = CS_SH1 & (CP1RD | CP1WR);
  assign wr_in[0] = CP0WR;
  assign wr_in[1] = CP1WR;
  assign ad_in[0] = CP0AD;
  assign ad_in[1] = CP1AD;
  assign do_in[0] = CP0DO;
  assign do_in[1] = CP1DO;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic       done_reg;
      logic [7:0] di_reg;

      // DONE only survives while the CPU keeps its strobe up, so an aborted cycle never leaves it set.
      always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
          done_reg <= 1'b0;
          di_reg   <= 8'h00;
        end else begin
          if (!req[gi])
            done_reg <= 1'b0;
          else if (state_reg == FIN && gnt_reg == 1'(gi))
            done_reg <= 1'b1;
          if (state_reg == CAP && !wr_reg && gnt_reg == 1'(gi))
            di_reg <= SHDI;
        end
      end

      assign pend[gi]   = req[gi] & ~done_reg;
      assign di_vec[gi] = di_reg;
    end
  endgenerate

  assign CP0WAIT_N = ~pend[0];
  assign CP1WAIT_N = ~pend[1];
  assign CP0DI     = di_vec[0];
  assign CP1DI     = di_vec[1];
  assign SHAD      = shad_reg;
  assign SHDO      = shdo_reg;
  assign SHWE      = shwe_reg;

`ifdef SHRAM_ARB_FAIR_EN
  // Stored as "CPU0 served last"; the cleared value therefore means CPU1 was last, so CPU0 wins first.
  logic last0_reg;
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N)
      last0_reg <= 1'b0;
    else if (state_reg == FIN)
      last0_reg <= ~gnt_reg;
  end
  assign sel = (&pend) ? last0_reg : ~pend[0];
`else
  assign sel = ~pend[0];
`endif

  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    case (state_reg)
      IDLE: if (|pend) begin
        start      = 1'b1;
        state_next = ACC;
      end
      ACC:     state_next = CAP;
      CAP:     state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // RAM address/data are loaded on the grant edge so they are stable for the whole ACC cycle and hold afterwards.
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg <= IDLE;
      gnt_reg   <= 1'b0;
      wr_reg    <= 1'b0;
      shwe_reg  <= 1'b0;
      shad_reg  <= '0;
      shdo_reg  <= 8'h00;
    end else begin
      state_reg <= state_next;
      if (start) begin
        gnt_reg  <= sel;
        wr_reg   <= wr_in[sel];
        shwe_reg <= wr_in[sel];
        shad_reg <= ad_in[sel];
        shdo_reg <= do_in[sel];
      end else begin
        shwe_reg <= 1'b0;
      end
    end
  end

endmodule
